// File: rtl/dram_pkg.sv
// dram_pkg: arbiter state encoding and command constants shared by the DRAM port arbiter.
package dram_pkg;
  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_ISSUE  = 2'd1,
    A_RDWAIT = 2'd2
  } arb_state_t;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;
endpackage

// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: client-side request/response bus plus the controller user port.
interface dram_port_arbiter_if #(
  parameter int NUM_PORTS    = 4,
  parameter int U_ADDR_WIDTH = 13,
  parameter int U_DATA_WIDTH = 8
);
  logic [NUM_PORTS-1:0]              p_req;
  logic [NUM_PORTS-1:0]              p_cmd;
  logic [NUM_PORTS*U_ADDR_WIDTH-1:0] p_addr;
  logic [NUM_PORTS*U_DATA_WIDTH-1:0] p_wdata;
  logic [NUM_PORTS-1:0]              p_gnt;
  logic [U_DATA_WIDTH-1:0]           p_rdata;
  logic [NUM_PORTS-1:0]              p_rvalid;
  logic [NUM_PORTS-1:0]              p_err;
  logic                              m_en;
  logic                              m_req;
  logic                              m_cmd;
  logic [U_ADDR_WIDTH-1:0]           m_addr;
  logic [U_DATA_WIDTH-1:0]           m_wdata;
  logic [U_DATA_WIDTH-1:0]           m_rdata;
  logic                              m_rvalid;
  logic                              m_ack;
  logic                              m_busy;
  // master is the arbiter; slave is the clients plus the controller around it
  modport master (
    input  p_req, p_cmd, p_addr, p_wdata, m_rdata, m_rvalid, m_ack, m_busy,
    output p_gnt, p_rdata, p_rvalid, p_err, m_en, m_req, m_cmd, m_addr, m_wdata
  );
  modport slave (
    output p_req, p_cmd, p_addr, p_wdata, m_rdata, m_rvalid, m_ack, m_busy,
    input  p_gnt, p_rdata, p_rvalid, p_err, m_en, m_req, m_cmd, m_addr, m_wdata
  );
endinterface

// File: rtl/dram_rr_picker.sv
// dram_rr_picker: combinational round-robin selector, scanning from rr_ptr+1 upward.
module dram_rr_picker #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]     req,
  input  logic [PORT_ID_WIDTH-1:0] rr_ptr,
  output logic                     found,
  output logic [PORT_ID_WIDTH-1:0] winner
);
  logic [PORT_ID_WIDTH-1:0] idx;
  // walk the scan order backwards so the nearest requester is the last to write
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = PORT_ID_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin sharing of one dram_controller user port, one command in flight,
// read data routed back to its owner and a watchdog that errors out stalled commands.
module dram_port_arbiter
  import dram_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int U_ADDR_WIDTH   = 13,
  parameter int U_DATA_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PORT_ID_WIDTH  = $clog2(NUM_PORTS),
  parameter int TMO_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     u_clk,
  input  logic                     u_rst_n,
  dram_port_arbiter_if.master      bus,
  output logic [PORT_ID_WIDTH-1:0] arb_owner,
  output logic                     arb_active
);
  arb_state_t               state, state_nxt;
  logic [PORT_ID_WIDTH-1:0] rr_ptr, owner, winner;
  logic [TMO_WIDTH-1:0]     tmo;
  logic                     found, grant, ack_ev, data_ev, expire;

  dram_rr_picker #(
    .NUM_PORTS    (NUM_PORTS),
    .PORT_ID_WIDTH(PORT_ID_WIDTH)
  ) u_picker (
    .req   (bus.p_req),
    .rr_ptr(rr_ptr),
    .found (found),
    .winner(winner)
  );

  // an ack or read-data event in the expiry cycle takes precedence over the timeout
  always_comb begin
    grant     = state == A_IDLE && found && !bus.m_busy;
    ack_ev    = state == A_ISSUE && bus.m_ack;
    data_ev   = state == A_RDWAIT && bus.m_rvalid;
    expire    = state != A_IDLE && !ack_ev && !data_ev && tmo <= TMO_WIDTH'(1);
    state_nxt = grant ? A_ISSUE :
                ack_ev ? (bus.m_cmd == CMD_READ ? A_RDWAIT : A_IDLE) :
                (data_ev || expire) ? A_IDLE : state;
  end

  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      state        <= A_IDLE;
      rr_ptr       <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      owner        <= '0;
      tmo          <= '0;
      bus.m_en     <= 1'b0;
      bus.m_req    <= 1'b0;
      bus.m_cmd    <= CMD_READ;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.p_gnt    <= '0;
      bus.p_rvalid <= '0;
      bus.p_err    <= '0;
      bus.p_rdata  <= '0;
    end else begin
      state        <= state_nxt;
      bus.m_en     <= 1'b1;
      bus.p_gnt    <= grant ? NUM_PORTS'(1) << winner : '0;
      bus.p_rvalid <= data_ev ? NUM_PORTS'(1) << owner : '0;
      bus.p_err    <= expire ? NUM_PORTS'(1) << owner : '0;
      tmo          <= (grant || ack_ev) ? TMO_WIDTH'(TIMEOUT_CYCLES) :
                      (state != A_IDLE && tmo != '0) ? tmo - TMO_WIDTH'(1) : tmo;
      if (grant) begin
        owner       <= winner;
        rr_ptr      <= winner;
        bus.m_req   <= 1'b1;
        bus.m_cmd   <= bus.p_cmd[winner];
        bus.m_addr  <= bus.p_addr[winner*U_ADDR_WIDTH +: U_ADDR_WIDTH];
        bus.m_wdata <= bus.p_wdata[winner*U_DATA_WIDTH +: U_DATA_WIDTH];
      end
      if (ack_ev || expire) bus.m_req <= 1'b0;
      if (data_ev) bus.p_rdata <= bus.m_rdata;
    end
  end

  assign arb_owner  = owner;
  assign arb_active = state != A_IDLE;
endmodule
